stage_d: RTL and testbench

- Consumer stage placed directly downstream of stage_C in the example pipeline.
- Accepts 8-bit tokens over the DIR/ack level-pulse handshake and buffers them in a small FIFO.
- Replaces each token with a running wrap-around sum of all tokens accepted since reset.
- Forwards results to the next stage over the same DOR/ack handshake.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_fifo.sv | 69 ++++++
 rtl/stage_d.sv | 115 +++++++++++
 tb/tb_stage_d.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the example pipeline stages (stage_C, stage_d and siblings).
package pipe_pkg;

    // Default token width and buffer depth for pipeline stages.
    localparam int unsigned PIPE_WIDTH = 8;
    localparam int unsigned PIPE_DEPTH = 4;

    // Output-side handshake FSM: IDLE=0, WAIT_ACK=1.
    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StWaitAck = 1'b1
    } out_state_e;

    // Handshake line levels shared by DIR/DOR/ack signalling.
    localparam logic HS_ASSERT = 1'b1;
    localparam logic HS_IDLE   = 1'b0;

endpackage

// File: rtl/pipe_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with occupancy count; DEPTH must be a power of two.
module pipe_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic [CntW-1:0]  count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Occupancy next-state: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/stage_d.sv
// Consumer stage: captures tokens over DIR/ack, replaces each with a running wrap-around
// sum, buffers results and forwards them over DOR/ack.
module stage_d
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_WIDTH,
    parameter int unsigned DEPTH = PIPE_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   DIR,
    input  logic [WIDTH-1:0]       data_in,
    output logic                   ack_prev,
    output logic                   DOR,
    output logic [WIDTH-1:0]       data_out,
    input  logic                   ack_from_next,
    output logic [$clog2(DEPTH):0] fill
);

    logic             capture;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             ack_q;
    logic             cooldown_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_head;

    out_state_e       state_q;
    out_state_e       state_d;
    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] data_out_d;

    // Carry is discarded: the sum wraps modulo 2^WIDTH.
    assign sum = acc_q + data_in;

    // Full is sampled before the edge, so a pop only frees a slot for the following edge.
    assign capture = (DIR == HS_ASSERT) && !cooldown_q && !fifo_full;

    pipe_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (sum),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fill)
    );

    // Accumulator advances only on a captured token.
    always_comb begin
        acc_d = acc_q;
        if (capture) begin
            acc_d = sum;
        end
    end

    // Input-side state: ack pulse and one-cycle cooldown so a still-held DIR is not recaptured.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            ack_q      <= HS_IDLE;
            cooldown_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            ack_q      <= capture;
            cooldown_q <= capture;
        end
    end

    // Output FSM next-state: pop into the output register from IDLE, hold until acked.
    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    data_out_d = fifo_head;
                    state_d    = StWaitAck;
                end
            end
            StWaitAck: begin
                if (ack_from_next == HS_ASSERT) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Output FSM state and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
        end
    end

    assign ack_prev = ack_q;
    assign DOR      = (state_q == StWaitAck);
    assign data_out = data_out_q;

endmodule

// File: tb/tb_stage_d.sv
// Self-checking bench for stage_d: scoreboard of expected running sums, one task per scenario.
`timescale 1ns/1ps
module tb_stage_d;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   DIR = 1'b0;
    logic [WIDTH-1:0]       data_in = '0;
    logic                   ack_prev;
    logic                   DOR;
    logic [WIDTH-1:0]       data_out;
    logic                   ack_from_next = 1'b0;
    logic [$clog2(DEPTH):0] fill;

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    int ack_cnt = 0;

    logic [WIDTH-1:0] model_acc = '0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mon_exp;

    always #5 clk = ~clk;

    stage_d #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .DIR           (DIR),
        .data_in       (data_in),
        .ack_prev      (ack_prev),
        .DOR           (DOR),
        .data_out      (data_out),
        .ack_from_next (ack_from_next),
        .fill          (fill)
    );

    // Monitor: inputs change just after posedge, so at negedge everything is settled.
    always @(negedge clk) begin
        if (!reset && ack_prev) begin
            ack_cnt++;
        end
        if (!reset && DOR && ack_from_next) begin
            out_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got data_out=%0d, required no output", data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (data_out !== mon_exp) begin
                    errors++;
                    $display("FAIL output_value: got data_out=%0d, required %0d", data_out, mon_exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        DIR   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_acc = '0;
        exp_q.delete();
    endtask

    // Raise DIR with a token and wait for its ack; returns at the negedge of the ack cycle.
    task automatic send_token(input logic [WIDTH-1:0] v);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        @(posedge clk); #1;
        DIR     = 1'b1;
        data_in = v;
        while (!got && n < 50) begin
            @(negedge clk);
            if (ack_prev === 1'b1) got = 1'b1;
            n++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_token: token %0d got no ack_prev, required one within 50 cycles", v);
            DIR = 1'b0;
        end else begin
            model_acc = model_acc + v;
            exp_q.push_back(model_acc);
        end
    endtask

    // Upstream drops DIR one cycle after seeing ack.
    task automatic release_dir();
        @(posedge clk); #1;
        DIR = 1'b0;
    endtask

    task automatic send_and_release(input logic [WIDTH-1:0] v);
        send_token(v);
        release_dir();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d outputs still pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (ack_prev !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack_prev: got %b, required 0", ack_prev);
        end
        checks++;
        if (DOR !== 1'b0) begin
            errors++;
            $display("FAIL reset_dor: got %b, required 0", DOR);
        end
        checks++;
        if (fill !== 3'd0) begin
            errors++;
            $display("FAIL reset_fill: got %0d, required 0", fill);
        end
        checks++;
        if (data_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_data_out: got %0d, required 0", data_out);
        end
    endtask

    task automatic test_single();
        int o0;
        int a0;
        do_reset();
        ack_from_next = 1'b1;
        o0 = out_cnt;
        a0 = ack_cnt;
        send_token(8'd5);
        // Ack cycle follows the capture edge; the pop happens on the next edge.
        checks++;
        if (DOR !== 1'b0) begin
            errors++;
            $display("FAIL single_dor_early: got DOR=%b in ack cycle, required 0", DOR);
        end
        release_dir();
        @(negedge clk);
        checks++;
        if (DOR !== 1'b1 || data_out !== 8'd5) begin
            errors++;
            $display("FAIL single_latency: got DOR=%b data_out=%0d, required DOR=1 data_out=5",
                     DOR, data_out);
        end
        wait_drain("single");
        checks++;
        if (out_cnt - o0 != 1) begin
            errors++;
            $display("FAIL single_out_count: got %0d outputs, required 1", out_cnt - o0);
        end
        checks++;
        if (ack_cnt - a0 != 1) begin
            errors++;
            $display("FAIL single_ack_count: got %0d acks, required 1", ack_cnt - a0);
        end
    endtask

    task automatic test_sequence();
        int o0;
        int a0;
        do_reset();
        ack_from_next = 1'b1;
        o0 = out_cnt;
        a0 = ack_cnt;
        send_and_release(8'd5);
        send_and_release(8'd10);
        send_and_release(8'd3);
        wait_drain("sequence");
        checks++;
        if (out_cnt - o0 != 3) begin
            errors++;
            $display("FAIL sequence_out_count: got %0d outputs, required 3", out_cnt - o0);
        end
        checks++;
        if (ack_cnt - a0 != 3) begin
            errors++;
            $display("FAIL sequence_ack_count: got %0d acks, required 3", ack_cnt - a0);
        end
    endtask

    // With the sink stalled, the first token moves into the output register and four more
    // fill the FIFO; the sixth must wait until the output drains.
    task automatic test_full();
        int a0;
        int o0;
        do_reset();
        ack_from_next = 1'b0;
        a0 = ack_cnt;
        o0 = out_cnt;
        for (int i = 0; i < 5; i++) begin
            send_and_release(8'd1);
        end
        @(posedge clk); #1;
        DIR     = 1'b1;
        data_in = 8'd1;
        repeat (6) @(negedge clk);
        checks++;
        if (ack_cnt - a0 != 5) begin
            errors++;
            $display("FAIL full_ack_count: got %0d acks, required 5", ack_cnt - a0);
        end
        checks++;
        if (fill !== 3'd4) begin
            errors++;
            $display("FAIL full_fill: got %0d, required 4", fill);
        end
        checks++;
        if (DOR !== 1'b1 || data_out !== 8'd1) begin
            errors++;
            $display("FAIL full_head: got DOR=%b data_out=%0d, required DOR=1 data_out=1",
                     DOR, data_out);
        end
        @(posedge clk); #1;
        ack_from_next = 1'b1;
        send_and_release(8'd1);
        wait_drain("full");
        checks++;
        if (out_cnt - o0 != 6) begin
            errors++;
            $display("FAIL full_out_count: got %0d outputs, required 6", out_cnt - o0);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        ack_from_next = 1'b1;
        send_and_release(8'd200);
        send_and_release(8'd100);
        send_and_release(8'd212);
        wait_drain("wrap");
    endtask

    // DIR is still high in the ack cycle; cooldown must stop a second capture.
    task automatic test_no_double();
        int a0;
        do_reset();
        ack_from_next = 1'b0;
        send_and_release(8'd9);
        repeat (2) @(negedge clk);
        a0 = ack_cnt;
        send_and_release(8'd4);
        repeat (3) @(negedge clk);
        checks++;
        if (fill !== 3'd1) begin
            errors++;
            $display("FAIL no_double_fill: got %0d, required 1", fill);
        end
        checks++;
        if (ack_cnt - a0 != 1) begin
            errors++;
            $display("FAIL no_double_acks: got %0d acks, required 1", ack_cnt - a0);
        end
        @(posedge clk); #1;
        ack_from_next = 1'b1;
        wait_drain("no_double");
    endtask

    task automatic test_reset_mid();
        do_reset();
        ack_from_next = 1'b0;
        send_and_release(8'd1);
        send_and_release(8'd2);
        send_and_release(8'd3);
        repeat (2) @(negedge clk);
        checks++;
        if (DOR !== 1'b1 || fill !== 3'd2) begin
            errors++;
            $display("FAIL mid_pre_reset: got DOR=%b fill=%0d, required DOR=1 fill=2", DOR, fill);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_acc = '0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (DOR !== 1'b0 || fill !== 3'd0 || data_out !== 8'd0) begin
            errors++;
            $display("FAIL mid_post_reset: got DOR=%b fill=%0d data_out=%0d, required 0 0 0",
                     DOR, fill, data_out);
        end
        @(posedge clk); #1;
        ack_from_next = 1'b1;
        send_and_release(8'd7);
        wait_drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_full();
        test_wrap();
        test_no_double();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
